irq_controller: RTL

//  Parametrised interrupt controller replacing the fixed 7-input mask in the MCU resources.

---
 rtl/irq_controller_pkg.sv | 27 ++
 rtl/irq_controller_sync.sv | 31 +++
 rtl/irq_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register offsets, vector layout
// and the bus write request record.
`ifndef IRQ_CONTROLLER_DEFS
`define IRQ_CONTROLLER_DEFS
`define IRQ_REG_PEND       3'd0
`define IRQ_REG_ENABLE     3'd1
`define IRQ_REG_MODE       3'd2
`define IRQ_REG_PRIO       3'd3
`define IRQ_REG_RAW        3'd4
`define IRQ_REG_VEC0       3'd5
`define IRQ_REG_VEC1       3'd6
`define IRQ_REG_SWSET      3'd7
`define IRQ_VEC_VALID_BIT  15
`endif

package irq_controller_pkg;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int IDX_W  = 4;

   typedef struct packed {
      logic              commit;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] mask;
      logic [DATA_W-1:0] data;
   } wr_req_t;
endpackage

// File: rtl/irq_controller_sync.sv
// One request channel: SYNC_STAGES-deep synchroniser plus a previous-sample flop
// that turns the synchronised level into a one-cycle rising-edge pulse.
module irq_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic level,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
      level  = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end
endmodule

// File: rtl/irq_controller.sv
// Parametrised interrupt controller: per-channel edge/level capture, masking and
// routing onto two registered CPU interrupt lines, with a 16-bit register window.
module irq_controller
   import irq_controller_pkg::*;
#(
   parameter int N_INTS      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              SEL,
   input  logic [2:0]        ADDR,
   input  logic [15:0]       DIN,
   output logic [15:0]       DOUT,
   input  logic              RDN,
   input  logic              WR0N,
   input  logic              WR1N,
   input  logic [N_INTS-1:0] INTS,
   output logic              INT0,
   output logic              INT1
);
   logic [N_INTS-1:0] level, rise;

   for (genvar g = 0; g < N_INTS; g++) begin : g_sync
      irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk     (CLK),
         .rst_n   (RESETN),
         .async_in(INTS[g]),
         .level   (level[g]),
         .rise    (rise[g])
      );
   end

   logic [N_INTS-1:0] pend_q, pend_d, enable_q, enable_d;
   logic [N_INTS-1:0] mode_q, mode_d, prio_q, prio_d;
   logic [N_INTS-1:0] w1c, swset, mode_chg, active, wmask_n, wdata_n;
   logic              wr0_q, wr0_d, wr1_q, wr1_d;
   logic              int0_q, int0_d, int1_q, int1_d;
   wr_req_t           wr;

   function automatic logic [15:0] zext(input logic [N_INTS-1:0] v);
      logic [15:0] r;
      r = '0;
      r[N_INTS-1:0] = v;
      return r;
   endfunction

   // Lowest-numbered set bit wins, so scan downwards and let the last hit stick.
   function automatic logic [15:0] vec_enc(input logic [N_INTS-1:0] v);
      logic [15:0] r;
      r = '0;
      for (int i = N_INTS - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = '0;
            r[`IRQ_VEC_VALID_BIT] = 1'b1;
            r[IDX_W-1:0] = IDX_W'(i);
         end
      end
      return r;
   endfunction

   // A strobe commits only on its high-to-low transition, once per assertion.
   always_comb begin
      wr0_d     = ~WR0N;
      wr1_d     = ~WR1N;
      wr.commit = SEL & ((~WR0N & ~wr0_q) | (~WR1N & ~wr1_q));
      wr.addr   = ADDR;
      wr.mask   = {{8{SEL & ~WR1N & ~wr1_q}}, {8{SEL & ~WR0N & ~wr0_q}}};
      wr.data   = DIN;
      wmask_n   = wr.mask[N_INTS-1:0];
      wdata_n   = wr.data[N_INTS-1:0];
   end

   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      prio_d   = prio_q;
      w1c      = '0;
      swset    = '0;
      if (wr.commit) begin
         case (wr.addr)
            `IRQ_REG_PEND:   w1c      = wmask_n & wdata_n;
            `IRQ_REG_ENABLE: enable_d = (enable_q & ~wmask_n) | (wdata_n & wmask_n);
            `IRQ_REG_MODE:   mode_d   = (mode_q & ~wmask_n) | (wdata_n & wmask_n);
            `IRQ_REG_PRIO:   prio_d   = (prio_q & ~wmask_n) | (wdata_n & wmask_n);
            `IRQ_REG_SWSET:  swset    = wmask_n & wdata_n;
            default: ;
         endcase
      end
      mode_chg = mode_q ^ mode_d;
      pend_d   = pend_q;
      // Set beats clear so an edge landing on a W1C or mode switch is never lost.
      for (int i = 0; i < N_INTS; i++) begin
         if (!mode_d[i])                           pend_d[i] = level[i];
         else if (rise[i] | (swset[i] & mode_q[i])) pend_d[i] = 1'b1;
         else if (w1c[i] | mode_chg[i])            pend_d[i] = 1'b0;
      end
      active = pend_q & enable_q;
      int0_d = |(active & prio_q);
      int1_d = |(active & ~prio_q);
   end

   always_comb begin
      DOUT = '0;
      if (SEL && !RDN) begin
         case (ADDR)
            `IRQ_REG_PEND:   DOUT = zext(pend_q);
            `IRQ_REG_ENABLE: DOUT = zext(enable_q);
            `IRQ_REG_MODE:   DOUT = zext(mode_q);
            `IRQ_REG_PRIO:   DOUT = zext(prio_q);
            `IRQ_REG_RAW:    DOUT = zext(level);
            `IRQ_REG_VEC0:   DOUT = vec_enc(active & prio_q);
            `IRQ_REG_VEC1:   DOUT = vec_enc(active & ~prio_q);
            default:         DOUT = '0;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         pend_q   <= '0;
         enable_q <= '0;
         mode_q   <= '0;
         prio_q   <= '0;
         wr0_q    <= 1'b0;
         wr1_q    <= 1'b0;
         int0_q   <= 1'b0;
         int1_q   <= 1'b0;
      end else begin
         pend_q   <= pend_d;
         enable_q <= enable_d;
         mode_q   <= mode_d;
         prio_q   <= prio_d;
         wr0_q    <= wr0_d;
         wr1_q    <= wr1_d;
         int0_q   <= int0_d;
         int1_q   <= int1_d;
      end
   end

   assign INT0 = int0_q;
   assign INT1 = int1_q;
endmodule
